// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// default datapath geometry.
package sub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bls_digit.sv
// One DIGIT-bit borrow-lookahead subtractor slice (purely combinational).
// d = x - y - bin over DIGIT bits, bout = borrow out of the slice.
module bls_digit
    import sub_pkg::*;
#(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // Bit i generates a borrow when x=0,y=1 and passes an incoming borrow when x==y.
    logic [DIGIT-1:0] g;
    logic [DIGIT-1:0] p;
    logic [DIGIT:0]   b;
    logic             acc;
    logic             run;

    assign g = ~x & y;
    assign p = ~(x ^ y);

    // Each borrow is a flat sum of products over lower generates, so no bit waits on its neighbour.
    always_comb begin
        b    = '0;
        acc  = 1'b0;
        run  = 1'b1;
        b[0] = bin;
        for (int i = 0; i < DIGIT; i++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (run & g[j]);
                run = run & p[j];
            end
            b[i+1] = acc | (run & bin);
        end
    end

    assign d    = x ^ y ^ b[DIGIT-1:0];
    assign bout = b[DIGIT];

endmodule

// File: rtl/digit_serial_sub.sv
// Digit-serial subtractor: D = X - Y - Bin, one DIGIT-bit slice per RUN cycle,
// LSB slice first, borrow carried between slices in a register.
// Handshake: start is sampled only in IDLE/DONE; the accepting edge latches
// X/Y/Bin. busy is high for the N = WIDTH/DIGIT RUN cycles; done is a one-cycle
// pulse when D/Bout (and V) become valid; results hold until the next accepted start.
// Optional feature: define DIGIT_SERIAL_SUB_OVERFLOW_EN to add the overflow output V.
module digit_serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output state_t           state_dbg
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Stop elaboration on a geometry that cannot be split into whole slices.
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("digit_serial_sub: illegal WIDTH/DIGIT combination");
    end

    state_t           state;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             borrow_r;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT-1:0] x_s;
    logic [DIGIT-1:0] y_s;
    logic [DIGIT-1:0] d_s;
    logic             b_s;

    assign x_s       = x_r[cnt*DIGIT +: DIGIT];
    assign y_s       = y_r[cnt*DIGIT +: DIGIT];
    assign state_dbg = state;

    bls_digit #(.DIGIT(DIGIT)) u_slice (
        .x    (x_s),
        .y    (y_s),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (b_s)
    );

    // Control FSM and datapath registers; reset wins over start and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            D        <= '0;
            Bout     <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
            V        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        x_r      <= X;
                        y_r      <= Y;
                        borrow_r <= Bin;
                        cnt      <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    D[cnt*DIGIT +: DIGIT] <= d_s;
                    borrow_r              <= b_s;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Bout  <= b_s;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
                        // The last slice holds the MSB of the difference.
                        V     <= (x_r[WIDTH-1] ^ y_r[WIDTH-1]) & (d_s[DIGIT-1] ^ x_r[WIDTH-1]);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_sub.sv
// Bench for digit_serial_sub: a cycle-count based reference model of the
// 16/4 instance checked every cycle, directed literal cases, randomized
// traffic, and a directed check of an 8/8 instance.
module tb_digit_serial_sub;
    import sub_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (16/4) ----------------
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] d;
    state_t       st;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
    logic         v;
`endif

    digit_serial_sub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (x),
        .Y         (y),
        .Bin       (bin),
        .busy      (busy),
        .done      (done),
        .D         (d),
        .Bout      (bout),
        .state_dbg (st)
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
        ,
        .V         (v)
`endif
    );

    // ---------------- second DUT (8/8, single slice) ----------------
    logic       s8 = 1'b0;
    logic [7:0] x8 = '0;
    logic [7:0] y8 = '0;
    logic       b8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
    state_t     st8;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
    logic       v8;
`endif

    digit_serial_sub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (s8),
        .X         (x8),
        .Y         (y8),
        .Bin       (b8),
        .busy      (busy8),
        .done      (done8),
        .D         (d8),
        .Bout      (bout8),
        .state_dbg (st8)
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
        ,
        .V         (v8)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline model: an accepted start at edge c finishes at edge c+N with
    // the arithmetic result X - Y - Bin computed in W+1 bits.
    int           cyc = 0;
    bit           m_ready = 0;
    bit           m_active = 0;
    int           m_due = 0;
    bit           m_done = 0;
    bit           m_valid = 0;
    logic [W-1:0] m_d = '0;
    logic         m_bout = 1'b0;
    logic         m_v = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W:0]   full;
    logic         p_bout, p_v;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ready  = 1;
            m_active = 0;
            m_done   = 0;
            m_valid  = 1;
            m_d      = '0;
            m_bout   = 1'b0;
            m_v      = 1'b0;
            exp_q.delete();
        end else if (m_active) begin
            if (cyc == m_due) begin
                m_active = 0;
                m_done   = 1;
                m_valid  = 1;
                m_d      = exp_q.pop_front();
                m_bout   = p_bout;
                m_v      = p_v;
            end
        end else begin
            m_done = 0;
            if (start) begin
                full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
                exp_q.push_back(full[W-1:0]);
                p_bout   = full[W];
                p_v      = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
                m_active = 1;
                m_due    = cyc + N;
                m_valid  = 0;
            end
        end
    end

    // Compare process: handshake every cycle, results whenever they are defined.
    always @(negedge clk) begin
        if (m_ready) begin
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_done));
            check("state_run", 32'(st == RUN), 32'(m_active));
            if (m_valid) begin
                check("D", 32'(d), 32'(m_d));
                check("Bout", 32'(bout), 32'(m_bout));
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
                check("V", 32'(v), 32'(m_v));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one operation starting at the current negedge; returns the number
    // of negedges until done was seen and how many of them had busy high.
    // poke > 0 re-asserts start with junk operands at that cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input int poke, output int lat, output int bcnt);
        x     = a;
        y     = b;
        bin   = bi;
        start = 1'b1;
        lat   = -1;
        bcnt  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == poke) begin
                start = 1'b1;
                x     = W'($urandom);
                y     = W'($urandom);
                bin   = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int lat, bc;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(d), 32'd0);
        check("rst_Bout", 32'(bout), 32'd0);
        check("rst_state", 32'(st), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // All-ones minus all-ones minus one.
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, lat, bc);
        check("ffff_latency", 32'(lat), 32'(N + 1));
        check("ffff_busy_cycles", 32'(bc), 32'(N));
        check("ffff_D", 32'(d), 32'h0000FFFF);
        check("ffff_Bout", 32'(bout), 32'd1);
        @(negedge clk);

        // Borrow ripples across every slice.
        do_op(16'h0000, 16'h0001, 1'b0, 0, lat, bc);
        check("ripple_D", 32'(d), 32'h0000FFFF);
        check("ripple_Bout", 32'(bout), 32'd1);
        @(negedge clk);

        do_op(16'h8000, 16'h0001, 1'b0, 0, lat, bc);
        check("ovf_D", 32'(d), 32'h00007FFF);
        check("ovf_Bout", 32'(bout), 32'd0);
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
        check("ovf_V", 32'(v), 32'd1);
`endif
        @(negedge clk);

        do_op(16'h0006, 16'h0001, 1'b0, 0, lat, bc);
        check("small_D", 32'(d), 32'h00000005);
        check("small_Bout", 32'(bout), 32'd0);
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
        check("small_V", 32'(v), 32'd0);
`endif
        @(negedge clk);

        // start re-asserted mid-operation must not disturb it.
        do_op(16'h1234, 16'h0034, 1'b0, 2, lat, bc);
        check("poke_latency", 32'(lat), 32'(N + 1));
        check("poke_D", 32'(d), 32'h00001200);
        check("poke_Bout", 32'(bout), 32'd0);

        // Back-to-back: second start issued at the done cycle.
        @(negedge clk);
        do_op(16'h0010, 16'h0020, 1'b0, 0, lat, bc);
        check("b2b1_D", 32'(d), 32'h0000FFF0);
        check("b2b1_Bout", 32'(bout), 32'd1);
        do_op(16'h5555, 16'h1111, 1'b1, 0, lat, bc);
        check("b2b2_latency", 32'(lat), 32'(N + 1));
        check("b2b2_D", 32'(d), 32'h00004443);
        check("b2b2_Bout", 32'(bout), 32'd0);
        @(negedge clk);

        // Reset during RUN cycle 2 aborts with no done pulse.
        x = 16'hABCD; y = 16'h1234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D", 32'(d), 32'd0);
        check("abort_Bout", 32'(bout), 32'd0);
        repeat (N + 2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        do_op(16'hABCD, 16'h1234, 1'b0, 0, lat, bc);
        check("after_abort_D", 32'(d), 32'h00009999);
        check("after_abort_Bout", 32'(bout), 32'd0);
        @(negedge clk);

        // Single-slice instance: done one cycle after the start edge.
        x8 = 8'h0C; y8 = 8'h03; b8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        check("w8_busy", 32'(busy8), 32'd1);
        check("w8_done_early", 32'(done8), 32'd0);
        @(negedge clk);
        check("w8_done", 32'(done8), 32'd1);
        check("w8_D", 32'(d8), 32'h08);
        check("w8_Bout", 32'(bout8), 32'd0);
        @(negedge clk);
        check("w8_done_pulse", 32'(done8), 32'd0);
        check("w8_D_hold", 32'(d8), 32'h08);

        // Randomized traffic: random start, operands and occasional resets.
        repeat (1500) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0: begin x = '0; y = 16'hFFFF; end
                1: begin x = W'($urandom); y = x; end
                default: begin x = W'($urandom); y = W'($urandom); end
            endcase
            bin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_sub.md
DIGIT_SERIAL_SUB -- requirements
Module: digit_serial_sub

Interface
- REQ-001 SHALL have parameter WIDTH, default 16: operand and difference width in bits.
- REQ-002 SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH mod DIGIT = 0 and 1 <= DIGIT <= WIDTH.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE or DONE.
- REQ-006 SHALL have port X, input, WIDTH bits: minuend.
- REQ-007 SHALL have port Y, input, WIDTH bits: subtrahend.
- REQ-008 SHALL have port Bin, input, 1 bit: borrow-in.
- REQ-009 SHALL have port busy, output, 1 bit: high while in RUN.
- REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when D/Bout become valid.
- REQ-011 SHALL have port D, output, WIDTH bits: difference X - Y - Bin mod 2^WIDTH.
- REQ-012 SHALL have port Bout, output, 1 bit: borrow-out, 1 iff X < Y + Bin (unsigned).

Function
- REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
- REQ-014 SHALL go IDLE->RUN or DONE->RUN on start=1, latching X, Y and Bin into internal registers in that same edge; X, Y and Bin are don't-care afterwards.
- REQ-015 SHALL process one DIGIT-bit slice per RUN cycle, LSB slice first, with the slice borrow-out registered as the next slice's borrow-in (initial borrow = latched Bin).
- REQ-016 SHALL stay in RUN for exactly N = WIDTH/DIGIT cycles, then enter DONE; done=1 for exactly the one cycle after the last slice is written; latency from the start edge to done=1 is N cycles.
- REQ-017 SHALL go DONE->IDLE when start=0, and DONE->RUN when start=1 (back-to-back operations with no idle gap).
- REQ-018 SHALL ignore start while in RUN; the in-flight operation and its latched operands are unaffected.
- REQ-019 SHALL update D slice by slice during RUN; D and Bout are valid only while done=1 and afterwards, and are held until the next start is accepted.
- REQ-020 SHALL, for DIGIT = WIDTH, complete in one RUN cycle (N = 1) with unchanged handshake.

Reset
- REQ-021 SHALL, on rst=1 at a clock edge, force state IDLE, busy=0, done=0, D=0, Bout=0, clear the internal borrow and operand registers, and have V=0 when present.
- REQ-022 SHALL give rst priority over start, and SHALL abort an in-flight operation with no done pulse.

Configuration
- REQ-023 SHALL, when macro DIGIT_SERIAL_SUB_OVERFLOW_EN is defined, provide output V (1 bit): two's-complement overflow, X[MSB] != Y[MSB] and D[MSB] != X[MSB], valid and held with D and reset to 0.
- REQ-024 SHALL, without DIGIT_SERIAL_SUB_OVERFLOW_EN, have no V port and no overflow logic; all other behaviour is identical.

Structure
- REQ-025 SHALL place the FSM state enum (IDLE/RUN/DONE) and the default WIDTH/DIGIT constants in shared package sub_pkg.
- REQ-026 SHALL implement the per-cycle slice as one combinational sub-module bls_digit: a DIGIT-bit borrow-lookahead subtractor with inputs x, y, bin and outputs d, bout.
- REQ-027 SHALL reject an illegal WIDTH/DIGIT combination at elaboration.

Verification (WIDTH=16, DIGIT=4 unless stated)
- REQ-028 SHALL cover: X=16'hFFFF, Y=16'hFFFF, Bin=1, start pulse -> busy for 4 cycles, done at cycle 4, D=16'hFFFF, Bout=1.
- REQ-029 SHALL cover: X=16'h0000, Y=16'h0001, Bin=0 -> D=16'hFFFF, Bout=1 (borrow ripples through all 4 slices).
- REQ-030 SHALL cover: X=16'h8000, Y=16'h0001, Bin=0 -> D=16'h7FFF, Bout=0, V=1 with the macro defined; also X=16'h0006, Y=16'h0001, Bin=0 -> D=16'h0005, Bout=0, V=0.
- REQ-031 SHALL cover: start re-asserted with new operands at RUN cycle 2 -> ignored, first result unchanged; start held high in DONE -> second operation starts immediately, done pulses 4 cycles later.
- REQ-032 SHALL cover: rst asserted at RUN cycle 2 -> next cycle IDLE, D=0, Bout=0, no done pulse; new start afterwards completes correctly.
- REQ-033 SHALL cover: WIDTH=8, DIGIT=8, X=8'h0C, Y=8'h03, Bin=1 -> done 1 cycle after start, D=8'h08, Bout=0.
